// File: rtl/fetch_unit.sv
// fetch_unit: PC-driven instruction fetch with one outstanding I-cache request and a small tagged instruction FIFO
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] icache_addr,
  output logic        icache_en,
  input  logic        icache_ack,
  input  logic [31:0] icache_do,
  output logic [31:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_pc
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [1:0] IDLE = 2'd0, FETCH = 2'd1, DISCARD = 2'd2;
  logic [1:0] state;
  logic [15:0] pc;
  logic [15:0] target;
  logic [31:0] buf_instr [FIFO_DEPTH];
  logic [15:0] buf_pc [FIFO_DEPTH];
  logic [AW-1:0] head, tail;
  logic [AW:0] count;
  logic push, pop;
  assign target = {redirect_pc[15:2], 2'b00};
  assign push = state == FETCH && icache_ack && !redirect;
  assign instr_valid = count != '0;
  assign pop = instr_valid && instr_ready;
  assign tail = head + count[AW-1:0];
  assign instr = instr_valid ? buf_instr[head] : '0;
  assign instr_pc = instr_valid ? buf_pc[head] : '0;
  // Request sequencing: issue from IDLE, wait for ack, swallow the ack of a redirected request
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      pc <= RESET_PC;
      icache_en <= 1'b0;
      icache_addr <= RESET_PC;
    end else begin
      case (state)
        IDLE: if (!redirect && count < FULL) begin
          state <= FETCH;
          icache_en <= 1'b1;
          icache_addr <= pc;
        end
        FETCH: if (icache_ack) begin
          state <= IDLE;
          icache_en <= 1'b0;
          pc <= pc + 16'd4;
        end else if (redirect) state <= DISCARD;
        DISCARD: if (icache_ack) begin
          state <= IDLE;
          icache_en <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      if (redirect) pc <= target;
    end
  end
  // Occupancy and head pointer; a redirect empties the buffer regardless of push/pop
  always_ff @(posedge clk) begin
    if (!reset || redirect) begin
      head <= '0;
      count <= '0;
    end else begin
      if (pop) head <= head + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  // Entry storage, written at the tail slot on each accepted fetch
  always_ff @(posedge clk) begin
    if (reset && push) begin
      buf_instr[tail] <= icache_do;
      buf_pc[tail] <= pc;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed checks of fetch_unit against a request-level queue model
module tb_fetch_unit;
  localparam logic [15:0] RST = 16'h0000;
  localparam int D = 4;
  logic clk = 0, reset = 0, icache_en, icache_ack = 0, instr_valid, instr_ready = 0, redirect = 0;
  logic [15:0] icache_addr, instr_pc, redirect_pc = 0;
  logic [31:0] icache_do = 0, instr;
  int checks = 0, passed = 0;
  logic [47:0] q[$];
  logic [15:0] m_pc, m_addr;
  bit m_busy, m_drop;

  fetch_unit #(.RESET_PC(RST), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .icache_addr(icache_addr), .icache_en(icache_en),
    .icache_ack(icache_ack), .icache_do(icache_do), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [65:0] dut_out();
    return {icache_en, icache_addr, instr_valid, instr, instr_pc};
  endfunction

  function automatic logic [65:0] model_out();
    logic [47:0] h = q.size() > 0 ? q[0] : 48'h0;
    return {m_busy, m_addr, q.size() > 0, h[31:0], h[47:32]};
  endfunction

  task automatic tick(input bit rn, input bit ack, input bit rdy, input bit rd, input logic [15:0] rpc, input logic [31:0] d);
    int sz;
    bit issue;
    reset = rn; icache_ack = ack; instr_ready = rdy; redirect = rd; redirect_pc = rpc; icache_do = d;
    if (!rn) begin
      q.delete(); m_pc = RST; m_addr = RST; m_busy = 0; m_drop = 0;
    end else begin
      sz = q.size();
      issue = !m_busy && !rd && sz < D;
      if (sz > 0 && rdy) void'(q.pop_front());
      if (m_busy && ack) begin
        if (!m_drop && !rd) begin
          q.push_back({m_addr, d});
          m_pc = m_addr + 16'd4;
        end
        m_busy = 0;
      end else if (issue) begin
        m_busy = 1; m_drop = 0; m_addr = m_pc;
      end
      if (rd) begin
        m_pc = {rpc[15:2], 2'b00};
        q.delete();
        if (m_busy) m_drop = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 1, 1, 0, 0, 32'h1234_5678);
    checks++;
    if (dut_out() !== {1'b0, RST, 1'b0, 32'h0, 16'h0}) $display("FAIL reset_const got %h want %h", dut_out(), {1'b0, RST, 1'b0, 32'h0, 16'h0});
    else passed++;
    checks++;
    if (dut_out() !== model_out()) $display("FAIL reset_model got %h want %h", dut_out(), model_out());
    else passed++;
  endtask

  task automatic test_sequential();
    logic [15:0] addrs[$];
    bit prev_en = 0;
    int low_run = 0;
    bit seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1, m_busy, 1, 0, 0, {16'hA5A5, m_addr});
      checks++;
      if (dut_out() !== model_out()) $display("FAIL seq_model cyc%0d got %h want %h", i, dut_out(), model_out());
      else passed++;
      if (icache_en && !prev_en) begin
        addrs.push_back(icache_addr);
        if (seen) begin
          checks++;
          if (low_run !== 1) $display("FAIL seq_gap got %0d want 1", low_run);
          else passed++;
        end
        seen = 1;
      end
      low_run = icache_en ? 0 : low_run + 1;
      prev_en = icache_en;
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (addrs.size() <= i || addrs[i] !== 16'(i * 4)) $display("FAIL seq_addr%0d got %h want %h", i, addrs.size() > i ? addrs[i] : 16'hxxxx, 16'(i * 4));
      else passed++;
    end
  endtask

  task automatic test_fill();
    int issues = 0;
    bit prev_en = 0;
    logic [15:0] pops[$];
    logic [15:0] resumed[$];
    tick(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 14; i++) begin
      tick(1, m_busy, 0, 0, 0, {16'hA5A5, m_addr});
      checks++;
      if (dut_out() !== model_out()) $display("FAIL fill_model cyc%0d got %h want %h", i, dut_out(), model_out());
      else passed++;
      if (icache_en && !prev_en) issues++;
      prev_en = icache_en;
    end
    checks++;
    if ({issues, icache_en, instr_valid, instr_pc} !== {32'd4, 1'b0, 1'b1, 16'h0000}) $display("FAIL fill_stop got %0d/%b/%b/%h want 4/0/1/0000", issues, icache_en, instr_valid, instr_pc);
    else passed++;
    for (int i = 0; i < 12; i++) begin
      if (instr_valid) pops.push_back(instr_pc);
      tick(1, m_busy, 1, 0, 0, {16'hA5A5, m_addr});
      checks++;
      if (dut_out() !== model_out()) $display("FAIL drain_model cyc%0d got %h want %h", i, dut_out(), model_out());
      else passed++;
      if (icache_en && !prev_en) resumed.push_back(icache_addr);
      prev_en = icache_en;
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (pops.size() <= i || pops[i] !== 16'(i * 4)) $display("FAIL drain_order%0d got %h want %h", i, pops.size() > i ? pops[i] : 16'hxxxx, 16'(i * 4));
      else passed++;
    end
    checks++;
    if (resumed.size() == 0 || resumed[0] !== 16'h0010) $display("FAIL fill_resume got %h want 0010", resumed.size() > 0 ? resumed[0] : 16'hxxxx);
    else passed++;
  endtask

  task automatic test_discard();
    tick(0, 0, 0, 0, 0, 0);
    tick(1, 0, 1, 1, 16'h0020, 0);
    tick(1, 0, 1, 0, 0, 0);
    for (int c = 1; c <= 5; c++) begin
      tick(1, c == 5, 1, c == 2, 16'h0103, 32'hDEAD_0020);
      checks++;
      if (dut_out() !== model_out()) $display("FAIL discard_model cyc%0d got %h want %h", c, dut_out(), model_out());
      else passed++;
      if (c < 5) begin
        checks++;
        if ({icache_en, icache_addr} !== {1'b1, 16'h0020}) $display("FAIL discard_hold cyc%0d got %b/%h want 1/0020", c, icache_en, icache_addr);
        else passed++;
      end
    end
    checks++;
    if ({instr_valid, icache_en} !== 2'b00) $display("FAIL discard_drop got %b/%b want 0/0", instr_valid, icache_en);
    else passed++;
    tick(1, 0, 1, 0, 0, 0);
    checks++;
    if ({icache_en, icache_addr, instr_valid} !== {1'b1, 16'h0100, 1'b0}) $display("FAIL discard_next got %b/%h/%b want 1/0100/0", icache_en, icache_addr, instr_valid);
    else passed++;
  endtask

  task automatic test_redirect_ack();
    int n = 0;
    tick(0, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 1, 16'h0038, 0);
    while (!(m_busy && m_addr == 16'h0040) && n < 20) begin
      tick(1, m_busy, 0, 0, 0, {16'hA5A5, m_addr});
      n++;
    end
    checks++;
    if (n >= 20 || instr_valid !== 1'b1 || q.size() != 2) $display("FAIL redir_setup got %0d cycles valid=%b want <20 valid=1", n, instr_valid);
    else passed++;
    tick(1, 1, 0, 1, 16'h0200, {16'hA5A5, 16'h0040});
    checks++;
    if ({icache_en, instr_valid} !== 2'b00) $display("FAIL redir_ack_flush got %b/%b want 0/0", icache_en, instr_valid);
    else passed++;
    tick(1, 0, 0, 0, 0, 0);
    checks++;
    if ({icache_en, icache_addr} !== {1'b1, 16'h0200} || dut_out() !== model_out()) $display("FAIL redir_ack_next got %h want %h", dut_out(), model_out());
    else passed++;
  endtask

  task automatic test_wrap();
    tick(0, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 1, 16'hFFFE, 0);
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 1, 0, 0, 0, {16'hA5A5, 16'hFFFC});
    checks++;
    if ({instr_valid, instr_pc, instr} !== {1'b1, 16'hFFFC, 32'hA5A5_FFFC}) $display("FAIL wrap_entry got %b/%h/%h want 1/fffc/a5a5fffc", instr_valid, instr_pc, instr);
    else passed++;
    tick(1, 0, 0, 0, 0, 0);
    checks++;
    if ({icache_en, icache_addr} !== {1'b1, 16'h0000}) $display("FAIL wrap_next got %b/%h want 1/0000", icache_en, icache_addr);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    tick(0, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 1, 16'h0080, 0);
    while (!(m_busy && q.size() == 3) && n < 30) begin
      tick(1, m_busy, 0, 0, 0, {16'hA5A5, m_addr});
      n++;
    end
    checks++;
    if (n >= 30 || icache_en !== 1'b1 || icache_addr !== 16'h008C) $display("FAIL rstmid_setup got %0d/%b/%h want <30/1/008c", n, icache_en, icache_addr);
    else passed++;
    tick(0, 0, 0, 0, 0, 0);
    checks++;
    if ({icache_en, instr_valid} !== 2'b00) $display("FAIL rstmid_clear got %b/%b want 0/0", icache_en, instr_valid);
    else passed++;
    tick(1, 1, 0, 0, 0, 32'hBAD0_BAD0);
    checks++;
    if ({icache_en, icache_addr, instr_valid} !== {1'b1, RST, 1'b0}) $display("FAIL rstmid_late_ack got %b/%h/%b want 1/%h/0", icache_en, icache_addr, instr_valid, RST);
    else passed++;
  endtask

  task automatic test_random();
    bit rn, ack, rd;
    logic [15:0] rpc;
    tick(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2000; i++) begin
      rn = ($urandom % 150) != 0;
      ack = m_busy ? ($urandom % 3 == 0) : ($urandom % 10 == 0);
      rd = ($urandom % 12) == 0;
      rpc = ($urandom % 4 == 0) ? 16'hFFF0 | 16'($urandom % 16) : 16'($urandom);
      tick(rn, ack, $urandom % 3 != 0, rd, rpc, $urandom);
      checks++;
      if (dut_out() !== model_out()) $display("FAIL random cyc%0d got %h want %h", i, dut_out(), model_out());
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_fill();
    test_discard();
    test_redirect_ack();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
